// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper pulse generator.
// Contents:
//   step_state_t  - pulse FSM state (IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW)
//   STEP_W/ACC_W  - pending-step width and the wider accumulation width
//   HOME_*_POS    - hardware positions loaded while an endstop is active
//   clamp_acc     - saturates an ACC_W accumulation result to +/-limit
package stepper_pkg;

  localparam int unsigned STEP_W = 16;
  localparam int unsigned ACC_W  = 18;

  localparam logic signed [STEP_W-1:0] HOME_LEFT_POS  = 16'sd1600;
  localparam logic signed [STEP_W-1:0] HOME_RIGHT_POS = 16'sd0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIR_SETUP  = 2'd1,
    PULSE_HIGH = 2'd2,
    PULSE_LOW  = 2'd3
  } step_state_t;

  typedef struct packed {
    logic signed [STEP_W-1:0] value;
    logic                     sat;
  } clamp_t;

  function automatic clamp_t clamp_acc(input logic signed [ACC_W-1:0] acc,
                                       input logic signed [ACC_W-1:0] limit);
    clamp_t r;
    r.sat   = 1'b0;
    r.value = STEP_W'(acc);
    if (acc > limit) begin
      r.value = STEP_W'(limit);
      r.sat   = 1'b1;
    end else if (acc < -limit) begin
      r.value = STEP_W'(-limit);
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter shared by the DIR_SETUP, PULSE_HIGH and PULSE_LOW
// phases of the step pulse generator.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   load          - load load_value this cycle (takes priority over counting)
//   load_value    - value loaded into the counter
//   done          - counter currently at zero
module step_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Converts per-tick signed microstep deltas from the physics simulator into
// STEP/DIR pulses for an external stepper driver with guaranteed STEP high,
// STEP low and DIR setup times, and enforces endstop inhibits.
// Ports:
//   clock, reset    - system clock, asynchronous active-high reset
//   sync_sim_clock  - simulator tick; rising edge samples delta_steps
//   delta_steps     - signed microstep delta for the tick
//   enable          - permits pulse issue (accumulation always continues)
//   end_left        - left endstop, inhibits positive steps
//   end_right       - right endstop, inhibits negative steps
//   step_out        - STEP to driver
//   dir_out         - DIR to driver, 1 = positive (toward left)
//   pending         - signed outstanding microsteps
//   busy            - FSM not in IDLE
//   overflow        - sticky, set when the accumulator saturates
//   step_pos        - (only with STEP_POS_COUNT_EN) hardware step position
// Optional feature macro: STEP_POS_COUNT_EN
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int unsigned PULSE_HIGH_CYC = 100,
  parameter int unsigned PULSE_LOW_CYC  = 100,
  parameter int unsigned DIR_SETUP_CYC  = 50,
  parameter int unsigned PENDING_MAX    = 4095
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sync_sim_clock,
  input  logic signed [STEP_W-1:0] delta_steps,
  input  logic                     enable,
  input  logic                     end_left,
  input  logic                     end_right,
  output logic                     step_out,
  output logic                     dir_out,
  output logic signed [STEP_W-1:0] pending,
  output logic                     busy,
  output logic                     overflow
`ifdef STEP_POS_COUNT_EN
  ,
  output logic signed [STEP_W-1:0] step_pos
`endif
);

  localparam int unsigned TIMER_W = 16;
  localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(DIR_SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] HIGH_LOAD  = TIMER_W'(PULSE_HIGH_CYC - 1);
  localparam logic [TIMER_W-1:0] LOW_LOAD   = TIMER_W'(PULSE_LOW_CYC - 1);
  localparam logic signed [ACC_W-1:0] LIMIT = ACC_W'(PENDING_MAX);

  step_state_t state;

  logic                     sync_d;
  logic                     tick;
  logic                     flush;
  logic signed [STEP_W-1:0] base;
  logic                     go;
  logic                     same_dir;
  logic                     abort_setup;
  logic                     launch;
  logic signed [ACC_W-1:0]  issue;
  logic signed [ACC_W-1:0]  delta_term;
  logic signed [ACC_W-1:0]  acc;
  clamp_t                   clamped;
  logic                     timer_load;
  logic [TIMER_W-1:0]       timer_value;
  logic                     timer_done;

  step_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_comb begin
    tick  = sync_sim_clock & ~sync_d;

    // Endstop flush only acts in IDLE; the launch decision and the
    // accumulation both use the flushed value so a flushed cycle never steps.
    flush = (state == IDLE) &&
            (((pending > 0) && end_left) || ((pending < 0) && end_right));
    base  = flush ? '0 : pending;

    go       = (state == IDLE) && enable && (base != '0);
    same_dir = ((base > 0) == dir_out);

    // Leave DIR_SETUP if the step it was preparing is no longer wanted or
    // would now drive into an active endstop.
    abort_setup = (state == DIR_SETUP) &&
                  (!enable || (pending == '0) || ((pending > 0) != dir_out) ||
                   (dir_out ? end_left : end_right));

    launch = (go && same_dir) ||
             ((state == DIR_SETUP) && !abort_setup && timer_done);

    issue      = launch ? (dir_out ? 18'sd1 : -18'sd1) : '0;
    delta_term = tick ? ACC_W'(delta_steps) : '0;
    acc        = ACC_W'(base) + delta_term - issue;
    clamped    = clamp_acc(acc, LIMIT);

    timer_load  = 1'b0;
    timer_value = '0;
    if (launch) begin
      timer_load  = 1'b1;
      timer_value = HIGH_LOAD;
    end else if (go) begin
      timer_load  = 1'b1;
      timer_value = SETUP_LOAD;
    end else if ((state == PULSE_HIGH) && timer_done) begin
      timer_load  = 1'b1;
      timer_value = LOW_LOAD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sync_d   <= 1'b0;
      step_out <= 1'b0;
      dir_out  <= 1'b1;
      pending  <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef STEP_POS_COUNT_EN
      step_pos <= '0;
`endif
    end else begin
      sync_d  <= sync_sim_clock;
      pending <= clamped.value;
      if (clamped.sat) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (go) begin
            busy <= 1'b1;
            if (same_dir) begin
              step_out <= 1'b1;
              state    <= PULSE_HIGH;
            end else begin
              dir_out <= ~dir_out;
              state   <= DIR_SETUP;
            end
          end
        end
        DIR_SETUP: begin
          if (abort_setup) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer_done) begin
            step_out <= 1'b1;
            state    <= PULSE_HIGH;
          end
        end
        PULSE_HIGH: begin
          if (timer_done) begin
            step_out <= 1'b0;
            state    <= PULSE_LOW;
          end
        end
        PULSE_LOW: begin
          if (timer_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          step_out <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase

`ifdef STEP_POS_COUNT_EN
      if (end_left) begin
        step_pos <= HOME_LEFT_POS;
      end else if (end_right) begin
        step_pos <= HOME_RIGHT_POS;
      end else if (launch) begin
        step_pos <= step_pos + (dir_out ? 16'sd1 : -16'sd1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen. A negedge monitor records pulse
// timing and the signed count of issued steps; scenario tasks compare those
// against values derived from the tick deltas they apply.
module tb_step_pulse_gen;

  logic               clock = 1'b0;
  logic               reset;
  logic               sync_sim_clock;
  logic signed [15:0] delta_steps;
  logic               enable;
  logic               end_left;
  logic               end_right;
  logic               step_out;
  logic               dir_out;
  logic signed [15:0] pending;
  logic               busy;
  logic               overflow;
`ifdef STEP_POS_COUNT_EN
  logic signed [15:0] step_pos;
`endif

  step_pulse_gen #(
    .PULSE_HIGH_CYC(100),
    .PULSE_LOW_CYC (100),
    .DIR_SETUP_CYC (50),
    .PENDING_MAX   (4095)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sync_sim_clock (sync_sim_clock),
    .delta_steps    (delta_steps),
    .enable         (enable),
    .end_left       (end_left),
    .end_right      (end_right),
    .step_out       (step_out),
    .dir_out        (dir_out),
    .pending        (pending),
    .busy           (busy),
    .overflow       (overflow)
`ifdef STEP_POS_COUNT_EN
    ,
    .step_pos       (step_pos)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Monitor state
  int cyc = 0;
  logic prev_step = 1'b0;
  logic prev_dir = 1'b1;
  int rise_cyc, fall_cyc, last_dir_chg;
  bit have_fall, dir_chg_pending, first_setup_seen;
  int rises, net, min_high, max_high, min_low, dir_while_high, min_setup, first_setup;

  task automatic clear_stats();
    rises = 0; net = 0; min_high = 1000000; max_high = 0; min_low = 1000000;
    dir_while_high = 0; min_setup = 1000000; first_setup = -1;
    have_fall = 0; dir_chg_pending = 0; first_setup_seen = 0;
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      prev_step = 1'b0;
      prev_dir = 1'b1;
      have_fall = 0;
      dir_chg_pending = 0;
    end else begin
      if (dir_out !== prev_dir) begin
        last_dir_chg = cyc;
        dir_chg_pending = 1;
        if (step_out) dir_while_high++;
      end
      if (step_out && !prev_step) begin
        rises++;
        net += dir_out ? 1 : -1;
        if (have_fall && (cyc - fall_cyc) < min_low) min_low = cyc - fall_cyc;
        if (dir_chg_pending) begin
          if ((cyc - last_dir_chg) < min_setup) min_setup = cyc - last_dir_chg;
          if (!first_setup_seen) begin
            first_setup = cyc - last_dir_chg;
            first_setup_seen = 1;
          end
          dir_chg_pending = 0;
        end
        rise_cyc = cyc;
      end
      if (!step_out && prev_step) begin
        if ((cyc - rise_cyc) < min_high) min_high = cyc - rise_cyc;
        if ((cyc - rise_cyc) > max_high) max_high = cyc - rise_cyc;
        fall_cyc = cyc;
        have_fall = 1;
      end
      prev_step = step_out;
      prev_dir = dir_out;
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    sync_sim_clock = 1'b0;
    delta_steps = '0;
    end_left = 1'b0;
    end_right = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    clear_stats();
  endtask

  task automatic do_tick(input int d);
    @(posedge clock);
    #1 delta_steps = 16'(d);
    sync_sim_clock = 1'b1;
    @(posedge clock);
    #1 sync_sim_clock = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int q = 0;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (!busy && pending == 0) q++; else q = 0;
      if (q >= 3) ok = 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rises(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clock);
      if (rises >= n && step_out) ok = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    sync_sim_clock = 1'b0;
    delta_steps = '0;
    end_left = 1'b0;
    end_right = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (step_out !== 1'b0) $display("FAIL reset_step: got %b expected 0", step_out); else passes++;
    checks++; if (dir_out !== 1'b1) $display("FAIL reset_dir: got %b expected 1", dir_out); else passes++;
    checks++; if (pending !== 16'sd0) $display("FAIL reset_pending: got %0d expected 0", pending); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passes++;
    apply_reset();
  endtask

  task automatic test_positive();
    bit ok;
    clear_stats();
    do_tick(3);
    checks++; if (pending !== 16'sd3) $display("FAIL pos_pending_after_tick: got %0d expected 3", pending); else passes++;
    wait_quiet(2000, ok);
    checks++; if (!ok) $display("FAIL pos_timeout: got 0 expected 1"); else passes++;
    checks++; if (rises !== 3) $display("FAIL pos_pulse_count: got %0d expected 3", rises); else passes++;
    checks++; if (net !== 3) $display("FAIL pos_net: got %0d expected 3", net); else passes++;
    checks++; if (min_high !== 100 || max_high !== 100) $display("FAIL pos_high_width: got %0d..%0d expected 100", min_high, max_high); else passes++;
    checks++; if (min_low < 100) $display("FAIL pos_low_width: got %0d expected >=100", min_low); else passes++;
    checks++; if (dir_out !== 1'b1) $display("FAIL pos_dir: got %b expected 1", dir_out); else passes++;
  endtask

  task automatic test_dir_change();
    bit ok;
    apply_reset();
    do_tick(-2);
    wait_quiet(2000, ok);
    checks++; if (!ok) $display("FAIL dir_timeout: got 0 expected 1"); else passes++;
    checks++; if (dir_out !== 1'b0) $display("FAIL dir_value: got %b expected 0", dir_out); else passes++;
    checks++; if (first_setup !== 50) $display("FAIL dir_setup: got %0d expected 50", first_setup); else passes++;
    checks++; if (rises !== 2 || net !== -2) $display("FAIL dir_pulses: got %0d net %0d expected 2 net -2", rises, net); else passes++;
    checks++; if (pending !== 16'sd0) $display("FAIL dir_pending: got %0d expected 0", pending); else passes++;
  endtask

  task automatic test_overflow();
    bit ok;
    int exp_p = 0;
    bit exp_sat = 0;
    apply_reset();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_p += 400;
      if (exp_p > 4095) begin exp_p = 4095; exp_sat = 1; end
      do_tick(400);
    end
    checks++; if (pending !== 16'(exp_p)) $display("FAIL ovf_pending: got %0d expected %0d", pending, exp_p); else passes++;
    checks++; if (overflow !== exp_sat) $display("FAIL ovf_flag: got %b expected %b", overflow, exp_sat); else passes++;
    checks++; if (rises !== 0) $display("FAIL ovf_no_pulse_disabled: got %0d expected 0", rises); else passes++;
    enable = 1'b1;
    wait_rises(2, 1000, ok);
    checks++; if (!ok) $display("FAIL ovf_drain_timeout: got 0 expected 1"); else passes++;
    checks++; if (pending !== 16'(exp_p - 2)) $display("FAIL ovf_drain_pending: got %0d expected %0d", pending, exp_p - 2); else passes++;
    end_left = 1'b1;
    wait_quiet(1000, ok);
    end_left = 1'b0;
    checks++; if (pending !== 16'sd0) $display("FAIL ovf_flushed: got %0d expected 0", pending); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else passes++;
    apply_reset();
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared_by_reset: got %b expected 0", overflow); else passes++;
  endtask

  task automatic test_endstop();
    bit ok;
    apply_reset();
    do_tick(5);
    wait_rises(2, 1000, ok);
    checks++; if (!ok) $display("FAIL end_second_pulse_timeout: got 0 expected 1"); else passes++;
    end_left = 1'b1;
    wait_quiet(1000, ok);
    checks++; if (min_high !== 100 || max_high !== 100) $display("FAIL end_pulse_completes: got %0d..%0d expected 100", min_high, max_high); else passes++;
    checks++; if (pending !== 16'sd0) $display("FAIL end_flush: got %0d expected 0", pending); else passes++;
    repeat (300) @(posedge clock);
    #1;
    checks++; if (rises !== 2) $display("FAIL end_no_more_steps: got %0d expected 2", rises); else passes++;
    do_tick(-2);
    wait_quiet(2000, ok);
    checks++; if (rises !== 4 || net !== 0) $display("FAIL end_negative_allowed: got %0d net %0d expected 4 net 0", rises, net); else passes++;
    end_left = 1'b0;
  endtask

  task automatic test_coincident();
    bit ok;
    apply_reset();
    enable = 1'b0;
    do_tick(1);
    @(posedge clock);
    #1 enable = 1'b1;
    delta_steps = 16'sd1;
    sync_sim_clock = 1'b1;
    @(posedge clock);
    #1 sync_sim_clock = 1'b0;
    checks++; if (pending !== 16'sd1) $display("FAIL coin_pending: got %0d expected 1", pending); else passes++;
    checks++; if (step_out !== 1'b1) $display("FAIL coin_launch: got %b expected 1", step_out); else passes++;
    wait_quiet(2000, ok);
    checks++; if (rises !== 2 || net !== 2) $display("FAIL coin_total: got %0d net %0d expected 2 net 2", rises, net); else passes++;
  endtask

  task automatic test_reset_mid_pulse();
    bit ok = 0;
    apply_reset();
    do_tick(2);
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      if (step_out) ok = 1;
    end
    checks++; if (!ok) $display("FAIL rst_mid_wait: got 0 expected 1"); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (step_out !== 1'b0) $display("FAIL rst_mid_step: got %b expected 0", step_out); else passes++;
    checks++; if (pending !== 16'sd0 || busy !== 1'b0) $display("FAIL rst_mid_state: got pending %0d busy %b expected 0 0", pending, busy); else passes++;
`ifdef STEP_POS_COUNT_EN
    checks++; if (step_pos !== 16'sd0) $display("FAIL rst_mid_pos: got %0d expected 0", step_pos); else passes++;
`endif
    @(posedge clock);
    #1 reset = 1'b0;
    clear_stats();
  endtask

  task automatic test_random();
    bit ok;
    int exp_net = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      int d = int'($urandom_range(12, 0)) - 6;
      exp_net += d;
      enable = ($urandom_range(3, 0) != 0);
      do_tick(d);
      repeat ($urandom_range(400, 2)) @(posedge clock);
      #1;
    end
    enable = 1'b1;
    wait_quiet(20000, ok);
    checks++; if (!ok) $display("FAIL rand_timeout: got 0 expected 1"); else passes++;
    checks++; if (net !== exp_net) $display("FAIL rand_net_steps: got %0d expected %0d", net, exp_net); else passes++;
    checks++; if (rises > 0 && (min_high !== 100 || max_high !== 100)) $display("FAIL rand_high_width: got %0d..%0d expected 100", min_high, max_high); else passes++;
    checks++; if (min_low < 100) $display("FAIL rand_low_width: got %0d expected >=100", min_low); else passes++;
    checks++; if (min_setup < 50) $display("FAIL rand_dir_setup: got %0d expected >=50", min_setup); else passes++;
    checks++; if (dir_while_high !== 0) $display("FAIL rand_dir_during_high: got %0d expected 0", dir_while_high); else passes++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_positive();
    test_dir_change();
    test_overflow();
    test_endstop();
    test_coincident();
    test_reset_mid_pulse();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Downstream of the physics simulator. Consumes the signed per-tick `delta_steps` (microstep units) on each rising edge of `sync_sim_clock`.
- Buffers the pending microsteps and replays them as STEP/DIR pulses to the external stepper driver, with guaranteed pulse-width and direction-setup timing.
- Enforces endstop inhibits.

Parameters:
- PULSE_HIGH_CYC, 100: STEP high time in clock cycles (2 us at 50 MHz).
- PULSE_LOW_CYC, 100: minimum STEP low time between pulses.
- DIR_SETUP_CYC, 50: cycles DIR must be stable before a STEP rising edge.
- PENDING_MAX, 4095: saturation magnitude of the pending-step accumulator.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sync_sim_clock  in  1  simulator tick, same clock domain; its rising edge marks new `delta_steps`.
- delta_steps  in  16  signed microstep delta for the current tick.
- enable  in  1  permits pulse issue; accumulation continues regardless.
- end_left  in  1  left endstop; inhibits positive steps.
- end_right  in  1  right endstop; inhibits negative steps.
- step_out  out  1  STEP to driver.
- dir_out  out  1  DIR to driver; 1 = positive (toward left).
- pending  out  16  signed outstanding microsteps.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; set when accumulation saturates.

Behaviour:
- Reset is clock = clock; reset = reset, asynchronous, active-high.
- Reset values:
  - step_out=0, dir_out=1, pending=0, busy=0, overflow=0.
  - FSM=IDLE, timer=0, tick-edge register=0.
  - Reset mid-pulse drops step_out immediately.
- Tick detect: `sync_sim_clock` registered once; rising edge detected in cycle N → pending updated at end of cycle N (visible N+1).
- Accumulate: pending_next = pending + delta_steps − issue, computed 18-bit signed.
  - issue = sign of the step being launched this cycle, else 0.
  - Result clamped to ±PENDING_MAX. Any clamp sets overflow, which clears only on reset.
  - A tick and a pulse launch in the same cycle both apply.
- Endstop flush: each cycle in IDLE, pending is forced to 0 if
  - pending>0 and end_left=1, or
  - pending<0 and end_right=1.
- FSM states IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW:
  - IDLE: when enable=1 and pending≠0 (after flush):
    - if sign(pending) matches dir_out → PULSE_HIGH;
    - else toggle dir_out, load timer=DIR_SETUP_CYC−1 → DIR_SETUP.
  - DIR_SETUP: count timer to 0 → PULSE_HIGH. If pending becomes 0 or changes sign meanwhile → IDLE.
  - Entry to PULSE_HIGH: step_out=1, pending decremented toward 0 by 1 (the issue term), timer=PULSE_HIGH_CYC−1.
  - PULSE_HIGH: at timer 0 → step_out=0, timer=PULSE_LOW_CYC−1 → PULSE_LOW.
  - PULSE_LOW: at timer 0 → IDLE, which may relaunch the next cycle.
  - Max rate: one step per PULSE_HIGH_CYC + PULSE_LOW_CYC + 1 cycles.
- Mid-pulse events:
  - enable deasserted mid-pulse: the current HIGH/LOW completes, then FSM holds in IDLE; pending is retained.
  - Endstop asserting mid-pulse: the pulse completes; the flush applies on return to IDLE.
- DIR changes only in IDLE, never while step_out=1.
- step_out and dir_out are driven directly from flops (glitch-free).

Optional Feature:
- Macro STEP_POS_COUNT_EN.
- Defined: adds output `step_pos` (16-bit signed) counting ±1 per issued pulse, reset to 0. It is also synchronously set to 1600 while end_left=1 and to 0 while end_right=1 (hardware position for cross-checking the simulator's current_pos).
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package stepper_pkg:
  - FSM state enum (2-bit);
  - STEP_W=16;
  - ACC_W=18;
  - HOME_LEFT_POS=16'd1600;
  - HOME_RIGHT_POS=16'd0.
- One sub-module, step_timer: a loadable down-counter with a `done` flag, shared by all three timed states.

Test Plan:
- Tick with delta_steps=+3, enable=1, dir_out=1 → exactly 3 pulses of 100 cycles high / ≥100 low; pending 3→0; dir_out stays 1.
- Tick delta=−2 after reset → dir_out→0, first STEP rise exactly 50 cycles later, 2 pulses, pending=0.
- 20 ticks of delta=+400 with enable=0 → pending saturates at 4095, overflow=1 and stays 1 after enable and draining.
- pending=+5, assert end_left during second pulse → that pulse completes, then pending=0 and no further STEP; negative delta still stepped.
- Tick coinciding with a pulse launch (pending=1, delta=+1) → pending stays 1 that cycle, with no lost or duplicated steps (total 2 pulses).
- Assert reset while step_out=1 → step_out=0 the same cycle, pending=0, busy=0; with STEP_POS_COUNT_EN, step_pos=0.
